chain_code_decoder: RTL and testbench

//  Receives a Freeman chain code serially (UART 8N1, LSB first) from the encoder and walks the contour from the start pixel.

---
 rtl/chain_code_pkg.sv | 47 ++++
 rtl/uart_rx_byte.sv | 117 +++++++++++
 rtl/chain_code_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_chain_code_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/chain_code_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chain_code_pkg
//  Description : Shared definitions for the Freeman chain-code decoder:
//                direction enum, per-direction step lookups, terminator code
//                and datapath widths.
//  Revision    : 1.0  initial release
// ============================================================================
package chain_code_pkg;

  localparam int COORD_W = 6;
  localparam int CNT_W   = 16;

  localparam logic [3:0] TERMINATOR = 4'hF;

  // Freeman directions, counter-clockwise from east; y grows downward.
  typedef enum logic [2:0] {
    DIR_E  = 3'd0,
    DIR_NE = 3'd1,
    DIR_N  = 3'd2,
    DIR_NW = 3'd3,
    DIR_W  = 3'd4,
    DIR_SW = 3'd5,
    DIR_S  = 3'd6,
    DIR_SE = 3'd7
  } dir_e;

  // Step in x: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
  function automatic logic [1:0] dir_dx(input dir_e d);
    case (d)
      DIR_E, DIR_NE, DIR_SE: return 2'b01;
      DIR_NW, DIR_W, DIR_SW: return 2'b11;
      default:               return 2'b00;
    endcase
  endfunction

  // Step in y (north is negative because rows count downward).
  function automatic logic [1:0] dir_dy(input dir_e d);
    case (d)
      DIR_NE, DIR_N, DIR_NW: return 2'b11;
      DIR_SW, DIR_S, DIR_SE: return 2'b01;
      default:               return 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : UART 8N1 receiver, LSB first, with 2-flop input synchroniser.
//                A frame whose start bit is not low at mid-bit is discarded
//                silently; a low stop bit raises frame_err instead of
//                byte_valid.
//  Revision    : 1.0  initial release
//  Ports       : CLK        in   clock
//                reset      in   asynchronous active-low reset
//                rx         in   serial line, idle high
//                byte_valid out  one-cycle pulse, rx_byte holds the data
//                rx_byte    out  received byte
//                frame_err  out  one-cycle pulse on a bad stop bit
// ============================================================================
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CNT_BITS = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_BITS-1:0] c_HALF_M1 = CNT_BITS'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_BITS-1:0] c_FULL_M1 = CNT_BITS'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          r_next;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_prev;
  logic [CNT_BITS-1:0] r_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                r_valid;
  logic                r_ferr;

  logic w_rx;
  logic w_fall;
  logic w_half;
  logic w_full;
  logic w_leave;
  logic w_shift_en;
  logic w_stop_smp;

  assign w_rx   = r_sync2;
  assign w_fall = r_prev & ~w_rx;
  assign w_half = (r_cnt == c_HALF_M1);
  assign w_full = (r_cnt == c_FULL_M1);

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= r_next;
  end

  // Next-state logic
  always_comb begin
    r_next = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) r_next = S_START;
      S_START: if (w_half) r_next = w_rx ? S_IDLE : S_DATA;
      S_DATA:  if (w_full && (r_bit_idx == 3'd7)) r_next = S_STOP;
      S_STOP:  if (w_full) r_next = S_IDLE;
      default: r_next = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_leave    = (r_next != r_state);
    w_shift_en = (r_state == S_DATA) && w_full;
    w_stop_smp = (r_state == S_STOP) && w_full;
  end

  // Synchroniser, bit timer and shift register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_prev    <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= w_rx;
      // Timer restarts on every state change so each bit is sampled mid-bit.
      if (w_leave || (r_state == S_IDLE)) r_cnt <= '0;
      else if (w_full)                    r_cnt <= '0;
      else                                r_cnt <= r_cnt + CNT_BITS'(1);
      if (r_state != S_DATA) r_bit_idx <= '0;
      else if (w_shift_en)   r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift_en) r_shift <= {w_rx, r_shift[7:1]};
      r_valid <= w_stop_smp & w_rx;
      r_ferr  <= w_stop_smp & ~w_rx;
    end
  end

  assign byte_valid = r_valid;
  assign rx_byte    = r_shift;
  assign frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: rtl/chain_code_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : chain_code_decoder
//  Description : Receives a Freeman chain code over UART (one packet per
//                byte, code in the low nibble), walks the contour from the
//                start pixel and, at the terminator, checks closure, step
//                count and optionally area against the encoder's figures.
//  Revision    : 1.0  initial release
//  Config      : DECODER_AREA_CHECK_EN enables the shoelace area accumulator
//                and its comparison against Area.
//  Ports       : CLK                in   clock
//                reset              in   asynchronous active-low reset
//                input_serial_bit   in   UART line, idle high
//                start              in   arm for a new contour (pulse)
//                start_pixel_x/y    in   contour start pixel
//                Area               in   encoder area
//                perimiter          in   encoder step count
//                Packet_Done_output out  pulse per accepted packet
//                ChainCode_ouput    out  nibble of last accepted packet
//                error              out  sticky error flag
//                current_x/y        out  current contour pixel
//                done               out  terminator processed (level)
// ============================================================================
module chain_code_decoder
  import chain_code_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               input_serial_bit,
  input  logic               start,
  input  logic [COORD_W-1:0] start_pixel_x,
  input  logic [COORD_W-1:0] start_pixel_y,
  input  logic [CNT_W-1:0]   Area,
  input  logic [CNT_W-1:0]   perimiter,
  output logic               Packet_Done_output,
  output logic [3:0]         ChainCode_ouput,
  output logic               error,
  output logic [COORD_W-1:0] current_x,
  output logic [COORD_W-1:0] current_y,
  output logic               done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         r_next;
  logic               r_pkt;
  logic [3:0]         r_code;
  logic               r_err;
  logic               r_done;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] r_sx;
  logic [COORD_W-1:0] r_sy;
  logic [CNT_W-1:0]   r_steps;

  logic             w_valid;
  logic [7:0]       w_byte;
  logic             w_ferr;
  logic [3:0]       w_code;
  dir_e             w_dir;
  logic [1:0]       w_dx;
  logic [1:0]       w_dy;
  logic [COORD_W:0] w_nx;
  logic [COORD_W:0] w_ny;
  logic             w_oob;
  logic             w_steps_full;
  logic             w_accept;
  logic             w_is_move;
  logic             w_is_bad;
  logic             w_ferr_run;
  logic             w_finish;
  logic             w_area_bad;
  logic             w_close_err;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .CLK        (CLK),
    .reset      (reset),
    .rx         (input_serial_bit),
    .byte_valid (w_valid),
    .rx_byte    (w_byte),
    .frame_err  (w_ferr)
  );

  assign w_code = w_byte[3:0];
  assign w_dir  = dir_e'(w_code[2:0]);
  assign w_dx   = dir_dx(w_dir);
  assign w_dy   = dir_dy(w_dir);

  // One extra bit catches leaving 0..63 in either direction; the low bits
  // give the modulo-64 wrap.
  assign w_nx  = {1'b0, r_x} + {{(COORD_W-1){w_dx[1]}}, w_dx};
  assign w_ny  = {1'b0, r_y} + {{(COORD_W-1){w_dy[1]}}, w_dy};
  assign w_oob = w_nx[COORD_W] | w_ny[COORD_W];

  assign w_steps_full = &r_steps;

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= r_next;
  end

  // Next-state logic; start overrides everything, including FINISH.
  always_comb begin
    r_next = r_state;
    if (start) begin
      r_next = S_RUN;
    end else begin
      case (r_state)
        S_IDLE:   r_next = S_IDLE;
        S_RUN:    if (w_valid && (w_code == TERMINATOR)) r_next = S_FINISH;
        S_FINISH: r_next = S_IDLE;
        default:  r_next = S_IDLE;
      endcase
    end
  end

  // Output / control decode; a packet arriving with start is dropped.
  always_comb begin
    w_accept   = (r_state == S_RUN) && w_valid && !start;
    w_is_move  = w_accept && !w_code[3];
    w_is_bad   = w_accept && w_code[3] && (w_code != TERMINATOR);
    w_ferr_run = (r_state == S_RUN) && w_ferr && !start;
    w_finish   = (r_state == S_FINISH) && !start;
  end

`ifdef DECODER_AREA_CHECK_EN
  // Doubled signed area (two's complement, 18 bits), pre-move coordinates.
  logic [17:0] r_a2;
  logic [17:0] w_xext;
  logic [17:0] w_yext;
  logic [17:0] w_xdy;
  logic [17:0] w_ydx;
  logic [17:0] w_abs;

  assign w_xext = {{(18-COORD_W){1'b0}}, r_x};
  assign w_yext = {{(18-COORD_W){1'b0}}, r_y};
  assign w_xdy  = w_dy[1] ? (18'd0 - w_xext) : (w_dy[0] ? w_xext : 18'd0);
  assign w_ydx  = w_dx[1] ? (18'd0 - w_yext) : (w_dx[0] ? w_yext : 18'd0);
  assign w_abs  = r_a2[17] ? (18'd0 - r_a2) : r_a2;
  assign w_area_bad = (w_abs[17:1] != {1'b0, Area});

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)         r_a2 <= '0;
    else if (start)     r_a2 <= '0;
    else if (w_is_move) r_a2 <= r_a2 + w_xdy - w_ydx;
  end

  logic w_unused;
  assign w_unused = ^w_byte[7:4];
`else
  assign w_area_bad = 1'b0;

  logic w_unused;
  assign w_unused = ^{w_byte[7:4], Area};
`endif

  assign w_close_err = (r_x != r_sx) || (r_y != r_sy) ||
                       (r_steps != perimiter) || w_area_bad;

  // Contour datapath
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_pkt   <= 1'b0;
      r_code  <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_sx    <= '0;
      r_sy    <= '0;
      r_steps <= '0;
    end else begin
      r_pkt <= w_accept;
      if (start) begin
        r_x     <= start_pixel_x;
        r_y     <= start_pixel_y;
        r_sx    <= start_pixel_x;
        r_sy    <= start_pixel_y;
        r_steps <= '0;
        r_err   <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        if (w_accept) r_code <= w_code;
        if (w_is_move) begin
          r_x <= w_nx[COORD_W-1:0];
          r_y <= w_ny[COORD_W-1:0];
          if (!w_steps_full) r_steps <= r_steps + CNT_W'(1);
          if (w_oob || w_steps_full) r_err <= 1'b1;
        end
        if (w_is_bad || w_ferr_run) r_err <= 1'b1;
        if (w_finish) begin
          r_done <= 1'b1;
          if (w_close_err) r_err <= 1'b1;
        end
      end
    end
  end

  assign Packet_Done_output = r_pkt;
  assign ChainCode_ouput    = r_code;
  assign error              = r_err;
  assign current_x          = r_x;
  assign current_y          = r_y;
  assign done               = r_done;

endmodule
`default_nettype wire

// File: tb/tb_chain_code_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chain_code_decoder
//  Description : Directed self-checking bench for chain_code_decoder with
//                CLKS_PER_BIT = 10 and hand-computed expected values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_chain_code_decoder;

  localparam int CPB = 10;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        input_serial_bit = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  start_pixel_x = '0;
  logic [5:0]  start_pixel_y = '0;
  logic [15:0] Area = '0;
  logic [15:0] perimiter = '0;
  logic        Packet_Done_output;
  logic [3:0]  ChainCode_ouput;
  logic        error;
  logic [5:0]  current_x;
  logic [5:0]  current_y;
  logic        done;

  chain_code_decoder #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .CLK                (CLK),
    .reset              (reset),
    .input_serial_bit   (input_serial_bit),
    .start              (start),
    .start_pixel_x      (start_pixel_x),
    .start_pixel_y      (start_pixel_y),
    .Area               (Area),
    .perimiter          (perimiter),
    .Packet_Done_output (Packet_Done_output),
    .ChainCode_ouput    (ChainCode_ouput),
    .error              (error),
    .current_x          (current_x),
    .current_y          (current_y),
    .done               (done)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  logic [5:0] q_x[$];
  logic [5:0] q_y[$];

  // Record every packet pulse with the position it reported.
  always @(negedge CLK) begin
    if (Packet_Done_output) begin
      n_pulses++;
      q_x.push_back(current_x);
      q_y.push_back(current_y);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    input_serial_bit = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      input_serial_bit = b[i];
      wait_clks(CPB);
    end
    input_serial_bit = stop_bit;
    wait_clks(CPB);
    input_serial_bit = 1'b1;
    wait_clks(2 * CPB);
  endtask

  task automatic pulse_start(input logic [5:0] x, input logic [5:0] y);
    start_pixel_x = x;
    start_pixel_y = y;
    start = 1'b1;
    wait_clks(1);
    start = 1'b0;
    wait_clks(1);
  endtask

  // Closed unit square from (10,10): E, S, W, N, terminator.
  task automatic run_square(input logic [15:0] perim, input logic [15:0] area,
                            output int base);
    perimiter = perim;
    Area      = area;
    pulse_start(6'd10, 6'd10);
    check_val("done_clear_on_start", {31'd0, done}, 32'd0);
    base = n_pulses;
    send_byte(8'h00, 1'b1);
    send_byte(8'h06, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h0F, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int ex[4];
    int ey[4];
    logic [31:0] exp_area_err;
    ex = '{11, 11, 10, 10};
    ey = '{10, 11, 11, 10};

    // 1. Reset asserted in the middle of a frame.
    wait_clks(3);
    reset = 1'b1;
    wait_clks(3);
    input_serial_bit = 1'b0;
    wait_clks(35);
    reset = 1'b0;
    wait_clks(2);
    check_val("rst_pkt",  {31'd0, Packet_Done_output}, 32'd0);
    check_val("rst_code", {28'd0, ChainCode_ouput}, 32'd0);
    check_val("rst_err",  {31'd0, error}, 32'd0);
    check_val("rst_x",    {26'd0, current_x}, 32'd0);
    check_val("rst_y",    {26'd0, current_y}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    input_serial_bit = 1'b1;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(5);
    base = n_pulses;
    send_byte(8'h00, 1'b1);
    check_val("idle_no_pulse", n_pulses - base, 32'd0);

    // 2. Closed square with matching figures.
    run_square(16'd4, 16'd1, base);
    check_val("sq_pulses", n_pulses - base, 32'd5);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("sq_x%0d", i), {26'd0, q_x[base + i]}, ex[i]);
      check_val($sformatf("sq_y%0d", i), {26'd0, q_y[base + i]}, ey[i]);
    end
    check_val("sq_code", {28'd0, ChainCode_ouput}, 32'hF);
    check_val("sq_done", {31'd0, done}, 32'd1);
    check_val("sq_err",  {31'd0, error}, 32'd0);

    // 3. Same stream, wrong perimeter.
    run_square(16'd5, 16'd1, base);
    check_val("perim_done", {31'd0, done}, 32'd1);
    check_val("perim_err",  {31'd0, error}, 32'd1);

    // 4. West from column 0 wraps to 63.
    pulse_start(6'd0, 6'd0);
    check_val("wrap_err_clear", {31'd0, error}, 32'd0);
    send_byte(8'h04, 1'b1);
    check_val("wrap_x",    {26'd0, current_x}, 32'd63);
    check_val("wrap_y",    {26'd0, current_y}, 32'd0);
    check_val("wrap_err",  {31'd0, error}, 32'd1);
    check_val("wrap_done", {31'd0, done}, 32'd0);

    // Reset during a frame while running clears all state.
    input_serial_bit = 1'b0;
    wait_clks(45);
    reset = 1'b0;
    wait_clks(2);
    check_val("rst2_x",   {26'd0, current_x}, 32'd0);
    check_val("rst2_err", {31'd0, error}, 32'd0);
    input_serial_bit = 1'b1;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(5);

    // 5. Illegal code, then a framing error.
    pulse_start(6'd20, 6'd20);
    send_byte(8'h09, 1'b1);
    check_val("bad_err",  {31'd0, error}, 32'd1);
    check_val("bad_code", {28'd0, ChainCode_ouput}, 32'd9);
    check_val("bad_x",    {26'd0, current_x}, 32'd20);
    check_val("bad_y",    {26'd0, current_y}, 32'd20);
    pulse_start(6'd20, 6'd20);
    check_val("ferr_err_clear", {31'd0, error}, 32'd0);
    base = n_pulses;
    send_byte(8'h00, 1'b0);
    check_val("ferr_no_pulse", n_pulses - base, 32'd0);
    check_val("ferr_err",      {31'd0, error}, 32'd1);
    check_val("ferr_x",        {26'd0, current_x}, 32'd20);

    // Terminator as the very first packet with zero perimeter.
    perimiter = 16'd0;
    Area      = 16'd0;
    pulse_start(6'd5, 6'd5);
    base = n_pulses;
    send_byte(8'h0F, 1'b1);
    check_val("term_pulses", n_pulses - base, 32'd1);
    check_val("term_done",   {31'd0, done}, 32'd1);
    check_val("term_err",    {31'd0, error}, 32'd0);

    // 6. Area mismatch (only detected with the area check built in).
`ifdef DECODER_AREA_CHECK_EN
    exp_area_err = 32'd1;
`else
    exp_area_err = 32'd0;
`endif
    run_square(16'd4, 16'd2, base);
    check_val("area_done", {31'd0, done}, 32'd1);
    check_val("area_err",  {31'd0, error}, exp_area_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
